// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the registered ALU.
// The master drives the operation and operands; the slave (the ALU)
// returns the registered result and condition flags.
interface alu_if #(
    parameter int bits = 16
);
    logic [2:0]      op;
    logic [bits-1:0] a;
    logic [bits-1:0] b;
    logic [bits-1:0] o;
    logic            c;
    logic            z;
    logic            v;
    logic            n;

    modport master (
        output op, a, b,
        input  o, c, z, v, n
    );

    modport slave (
        input  op, a, b,
        output o, c, z, v, n
    );
endinterface : alu_if

// File: rtl/alu.sv
// Registered ALU for the v68k datapath.
// One operation per cycle: result and 68k-style C/Z/V/N flags are computed
// combinationally from op/a/b and captured on the next rising edge.
module alu #(
    parameter int bits = 16
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    localparam int MSB = bits - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LSL = 3'b110,
        OP_LSR = 3'b111
    } op_e;

    op_e             w_op;
    logic [bits:0]   w_sum;   // a + b with carry out in the top bit
    logic [bits:0]   w_diff;  // a - b with borrow in the top bit
    logic [bits-1:0] w_res;
    logic            w_c;
    logic            w_v;

    logic [bits-1:0] r_o;
    logic            r_c;
    logic            r_z;
    logic            r_v;
    logic            r_n;

    assign w_op   = op_e'(bus.op);
    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

    // Result, carry/borrow and overflow for the selected operation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[bits];
                // Same-sign operands whose sum changes sign.
                w_v   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                // The wrapped top bit is 1 exactly when a < b unsigned.
                w_c   = w_diff[bits];
                // Opposite-sign operands whose difference leaves a's sign.
                w_v   = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_NOT: w_res = ~bus.a;
            OP_LSL: begin
                w_res = {bus.a[MSB-1:0], 1'b0};
                w_c   = bus.a[MSB];
            end
            OP_LSR: begin
                w_res = {1'b0, bus.a[MSB:1]};
                w_c   = bus.a[0];
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    // Capture result and flags; synchronous reset takes priority.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_o <= '0;
            r_c <= 1'b0;
            r_z <= 1'b0;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else begin
            r_o <= w_res;
            r_c <= w_c;
            r_z <= (w_res == '0);
            r_v <= w_v;
            r_n <= w_res[MSB];
        end
    end

    assign bus.o = r_o;
    assign bus.c = r_c;
    assign bus.z = r_z;
    assign bus.v = r_v;
    assign bus.n = r_n;
endmodule : alu

// File: tb/tb_alu.sv
// Bench for the registered ALU: directed test-plan vectors with literal
// expectations, then randomized operations checked every cycle against an
// arithmetic reference model.
module tb_alu;
    localparam int    W    = 16;
    localparam longint MOD  = longint'(1) << W;
    localparam longint HALF = longint'(1) << (W - 1);

    typedef struct packed {
        logic [W-1:0] o;
        logic         c;
        logic         z;
        logic         v;
        logic         n;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    res_t exp_r;
    logic exp_valid = 1'b0;

    alu_if #(.bits(W)) bus ();

    alu #(.bits(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: values treated as plain integers, signed overflow judged by
    // whether the true signed result fits in W bits.
    function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   r;
        longint ua, ub, sa, sb, sr, val;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = (ua >= HALF) ? ua - MOD : ua;
        sb  = (ub >= HALF) ? ub - MOD : ub;
        r   = '0;
        val = 0;
        case (op)
            3'd0: begin
                val = ua + ub;
                r.c = (val >= MOD);
                sr  = sa + sb;
                r.v = (sr > HALF - 1) || (sr < -HALF);
                val = val % MOD;
            end
            3'd1: begin
                r.c = (ua < ub);
                sr  = sa - sb;
                r.v = (sr > HALF - 1) || (sr < -HALF);
                val = (ua - ub + MOD) % MOD;
            end
            3'd2: val = longint'(a & b);
            3'd3: val = longint'(a | b);
            3'd4: val = longint'(a ^ b);
            3'd5: val = MOD - 1 - ua;
            3'd6: begin
                val = (ua * 2) % MOD;
                r.c = (ua >= HALF);
            end
            default: begin
                val = ua / 2;
                r.c = (ua % 2) == 1;
            end
        endcase
        r.o = val[W-1:0];
        r.z = (val == 0);
        r.n = (val >= HALF);
        return r;
    endfunction

    // Expected outputs for the inputs sampled at this edge.
    always @(posedge clk) begin
        exp_r     <= reset ? '0 : model(bus.op, bus.a, bus.b);
        exp_valid <= 1'b1;
    end

    // Every-cycle comparison, half a cycle after the capturing edge.
    always @(negedge clk) begin
        if (exp_valid)
            check("cycle", 32'({bus.o, bus.c, bus.z, bus.v, bus.n}), 32'(exp_r));
    end

    task automatic directed(input string name, input logic rst, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b, input res_t exp);
        @(negedge clk);
        reset  = rst;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        if (!rst)
            check({name, " model"}, 32'(model(op, a, b)), 32'(exp));
        @(posedge clk);
        #1;
        check(name, 32'({bus.o, bus.c, bus.z, bus.v, bus.n}), 32'(exp));
    endtask

    function automatic res_t mk(input logic [W-1:0] o, input logic c, input logic z,
                                input logic v, input logic n);
        res_t r;
        r = {o, c, z, v, n};
        return r;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corner [5];
        corner[0] = '0;
        corner[1] = W'(1);
        corner[2] = W'(HALF - 1);
        corner[3] = W'(HALF);
        corner[4] = '1;
        if ($urandom_range(3) == 0)
            return corner[$urandom_range(4)];
        return W'($urandom);
    endfunction

    initial begin
        bus.op = 3'd0;
        bus.a  = '0;
        bus.b  = '0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'({bus.o, bus.c, bus.z, bus.v, bus.n}), 32'(0));

        directed("add 0+0",        1'b0, 3'd0, 16'h0000, 16'h0000, mk(16'h0000, 0, 1, 0, 0));
        directed("add 010F+010F",  1'b0, 3'd0, 16'h010F, 16'h010F, mk(16'h021E, 0, 0, 0, 0));
        directed("add maxpos+1",   1'b0, 3'd0, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 0, 1, 1));
        directed("add ones+1",     1'b0, 3'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 1, 0, 0));
        directed("add ones+ones",  1'b0, 3'd0, 16'hFFFF, 16'hFFFF, mk(16'hFFFE, 1, 0, 0, 1));
        directed("add FFFF+1000",  1'b0, 3'd0, 16'hFFFF, 16'h1000, mk(16'h0FFF, 1, 0, 0, 0));
        directed("add mixed sign", 1'b0, 3'd0, 16'h8000, 16'h7FFF, mk(16'hFFFF, 0, 0, 0, 1));
        directed("sub 0-1",        1'b0, 3'd1, 16'h0000, 16'h0001, mk(16'hFFFF, 1, 0, 0, 1));
        directed("sub minneg-1",   1'b0, 3'd1, 16'h8000, 16'h0001, mk(16'h7FFF, 0, 0, 1, 0));
        directed("and",            1'b0, 3'd2, 16'hF0F0, 16'h3C3C, mk(16'h3030, 0, 0, 0, 0));
        directed("or",             1'b0, 3'd3, 16'h0F00, 16'h8001, mk(16'h8F01, 0, 0, 0, 1));
        directed("xor self",       1'b0, 3'd4, 16'hA5A5, 16'hA5A5, mk(16'h0000, 0, 1, 0, 0));
        directed("not 0",          1'b0, 3'd5, 16'h0000, 16'h1234, mk(16'hFFFF, 0, 0, 0, 1));
        directed("lsl 8001",       1'b0, 3'd6, 16'h8001, 16'h0000, mk(16'h0002, 1, 0, 0, 0));
        directed("lsr 0001",       1'b0, 3'd7, 16'h0001, 16'h0000, mk(16'h0000, 1, 1, 0, 0));
        directed("lsr 8000",       1'b0, 3'd7, 16'h8000, 16'h0000, mk(16'h4000, 0, 0, 0, 0));
        directed("pre-reset add",  1'b0, 3'd0, 16'h7FFF, 16'h7FFF, mk(16'hFFFE, 0, 0, 1, 1));
        directed("reset mid",      1'b1, 3'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 0, 0, 0, 0));
        directed("after reset",    1'b0, 3'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 1, 0, 0));

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            reset  = ($urandom_range(49) == 0);
            bus.op = 3'($urandom_range(7));
            bus.a  = pick_operand();
            bus.b  = pick_operand();
        end

        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_alu

// File: doc/alu.md
Name: alu

Overview:
- Parameterised-width registered ALU for the v68k datapath.
- Computes an arithmetic or logic result from two operands plus 68k-style condition flags: C (carry/borrow), Z (zero), V (signed overflow), N (negative).
- Result and flags are captured in registers on each rising clock edge.
- Consumed by the execute stage and the condition-code register logic.

Parameters:
- bits, 16, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  3  operation select.
- a  input  bits  operand A.
- b  input  bits  operand B.
- o  output  bits  registered result.
- c  output  1  registered carry/borrow flag.
- z  output  1  registered zero flag.
- v  output  1  registered signed-overflow flag.
- n  output  1  registered negative flag.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset; no handshake.
- Reset: on a rising edge with reset=1, o=0, c=0, z=0, v=0, n=0. Reset has priority over computation. Reset is sampled only at clock edges; asserting it mid-stream clears outputs at that edge only.
- Latency: one cycle. a, b and op sampled at rising edge k drive o/c/z/v/n from edge k until edge k+1.
- Throughput: a new operation is accepted every cycle; no internal state besides the output registers.
- Operations (op):
  - 000 ADD: o = a + b mod 2^bits.
  - 001 SUB: o = a - b mod 2^bits.
  - 010 AND: o = a & b.
  - 011 OR: o = a | b.
  - 100 XOR: o = a ^ b.
  - 101 NOT: o = ~a (b ignored).
  - 110 LSL: o = a shifted left one bit, 0 in at LSB.
  - 111 LSR: o = a shifted right one bit, 0 in at MSB.
- Flag rules:
  - n = o[bits-1] for all ops.
  - z = 1 iff o == 0 for all ops.
  - ADD: c = carry out of bit bits-1 (a + b computed at bits+1 width). v = 1 iff a and b have the same sign and o's sign differs from it.
  - SUB: c = borrow, i.e. 1 iff unsigned a < unsigned b. v = 1 iff a and b have different signs and o's sign differs from a's.
  - AND/OR/XOR/NOT: c = 0, v = 0.
  - LSL: c = a[bits-1], v = 0.
  - LSR: c = a[0], v = 0.
- Boundary values:
  - Max positive + 1 overflows to min negative with v=1, c=0.
  - All-ones + 1 wraps to 0 with c=1, z=1, v=0.
  - Mixed-sign ADD never sets v.
- No X propagation: outputs are fully defined after the first reset edge, and also whenever inputs are known.

Test Plan:
- ADD, bits=16, a=0000, b=0000 -> after one edge: o=0000, c=0, z=1, v=0, n=0.
- ADD a=010F, b=010F -> o=021E, c=0, z=0, v=0, n=0.
- ADD a=7FFF, b=0001 -> o=8000, c=0, z=0, v=1, n=1.
- ADD a=FFFF, b=0001 -> o=0000, c=1, z=1, v=0, n=0.
- ADD a=FFFF, b=FFFF -> o=FFFE, c=1, v=0, n=1. ADD a=FFFF, b=1000 -> o=0FFF, c=1, v=0, n=0.
- SUB a=0000, b=0001 -> o=FFFF, c=1, v=0, n=1. SUB a=8000, b=0001 -> o=7FFF, v=1, c=0. LSL a=8001 -> o=0002, c=1. Assert reset with a=FFFF, b=0001 -> all outputs 0 at that edge.
